// File: rtl/hamming_pkg.sv
// Shared definitions for the SEC-DED Hamming codec family.
// Provides parity-width and codeword-width helpers, the data-index to
// Hamming-position mapping, and the decode status encoding.
package hamming_pkg;

    typedef enum logic [1:0] {
        ECC_OK  = 2'd0,
        ECC_SEC = 2'd1,
        ECC_DED = 2'd2
    } ecc_status_e;

    // Upper bound on Hamming positions scanned by the helpers (covers DATA_W=64).
    localparam int HAMMING_MAX_POS = 128;

    // Smallest P with 2^P >= data_w + P + 1.
    function automatic int hamming_par_w(input int data_w);
        int p;
        p = 1;
        for (int k = 0; k < 8; k++) begin
            if ((1 << p) < data_w + p + 1) begin
                p = p + 1;
            end
        end
        return p;
    endfunction

    // Full codeword width: data + check bits + overall parity bit.
    function automatic int hamming_code_w(input int data_w);
        return data_w + hamming_par_w(data_w) + 1;
    endfunction

    // True when pos is a check-bit position (a power of two).
    function automatic bit hamming_is_check(input int pos);
        return (pos != 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Hamming position of data bit idx: the idx-th non-power-of-two position >= 3.
    function automatic int hamming_data_pos(input int idx);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int q = 3; q < HAMMING_MAX_POS; q++) begin
            if (!hamming_is_check(q)) begin
                if (cnt == idx) begin
                    pos = q;
                end
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome generator for the SEC-DED Hamming code.
// o_syn is the XOR of the positions of all set bits in i_code[N-1:1];
// o_ovr is the XOR of every codeword bit (overall parity mismatch).
// Shared by the decoder pipeline and the encoder's check-bit generation.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [hamming_code_w(DATA_W)-1:0] i_code,
    output logic [hamming_par_w(DATA_W)-1:0]  o_syn,
    output logic                              o_ovr
);

    localparam int P = hamming_par_w(DATA_W);
    localparam int N = hamming_code_w(DATA_W);

    logic [P-1:0] w_syn;

    // Fold the position index of every set bit into the syndrome.
    always_comb begin
        w_syn = '0;
        for (int i = 1; i < N; i++) begin
            if (i_code[i]) begin
                w_syn = w_syn ^ P'(i);
            end
        end
    end

    assign o_syn = w_syn;
    assign o_ovr = ^i_code;

endmodule

// File: rtl/hamming_secded_dec_pipe.sv
// Pipelined, parametrised SEC-DED Hamming decoder on a valid/ready stream.
// Ranks: p0 captures the accepted codeword, p1 holds codeword + syndrome +
// overall-parity mismatch, p2 holds corrected data and status. All ranks
// advance together on a single global enable, so a word accepted at edge k
// is presented at the output after edge k+2.
// Optional macro HAMMING_ERR_CNT_EN adds saturating SEC/DED counters; when it
// is undefined the counter outputs are tied to zero and cnt_clr is ignored.
module hamming_secded_dec_pipe
    import hamming_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                              sys_clk,
    input  logic                              rstn,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [hamming_code_w(DATA_W)-1:0] in_code,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic                              out_sec,
    output logic                              out_ded,
    input  logic                              cnt_clr,
    output logic [CNT_W-1:0]                  cnt_sec,
    output logic [CNT_W-1:0]                  cnt_ded
);

    localparam int P = hamming_par_w(DATA_W);
    localparam int N = hamming_code_w(DATA_W);

    // Largest syndrome that still names a real codeword position.
    localparam logic [P-1:0] SYN_MAX = P'(N - 1);
    localparam logic [N-1:0] ONE_N   = N'(1);

    logic              w_adv;

    logic              r_vld_p0;
    logic [N-1:0]      r_code_p0;
    logic [P-1:0]      w_syn_p0;
    logic              w_ovr_p0;

    logic              r_vld_p1;
    logic [N-1:0]      r_code_p1;
    logic [P-1:0]      r_syn_p1;
    logic              r_ovr_p1;
    logic [N-1:0]      w_corr_p1;
    ecc_status_e       w_stat_p1;
    logic [DATA_W-1:0] w_data_p1;

    logic              r_vld_p2;
    logic [DATA_W-1:0] r_data_p2;
    logic              r_sec_p2;
    logic              r_ded_p2;

    // Whole pipe moves when the output slot is empty or being drained.
    assign w_adv    = ~r_vld_p2 | out_ready;
    assign in_ready = w_adv;

    // Valid bits shift as one; an async reset drops every in-flight word.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p0 <= in_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // ---- p0: capture the accepted codeword ----
    always_ff @(posedge sys_clk) begin
        if (w_adv && in_valid) begin
            r_code_p0 <= in_code;
        end
    end

    hamming_syndrome #(
        .DATA_W (DATA_W)
    ) u_syndrome (
        .i_code (r_code_p0),
        .o_syn  (w_syn_p0),
        .o_ovr  (w_ovr_p0)
    );

    // ---- p1: register codeword, syndrome and overall parity mismatch ----
    always_ff @(posedge sys_clk) begin
        if (w_adv && r_vld_p0) begin
            r_code_p1 <= r_code_p0;
            r_syn_p1  <= w_syn_p0;
            r_ovr_p1  <= w_ovr_p0;
        end
    end

    // Classify the word and flip the faulty position for a single error.
    // Syndrome 0 with parity mismatch flips bit 0 (the overall parity bit).
    always_comb begin
        w_stat_p1 = ECC_OK;
        w_corr_p1 = r_code_p1;
        if (r_ovr_p1) begin
            if (r_syn_p1 > SYN_MAX) begin
                w_stat_p1 = ECC_DED;
            end else begin
                w_stat_p1 = ECC_SEC;
                w_corr_p1 = r_code_p1 ^ (ONE_N << r_syn_p1);
            end
        end else if (r_syn_p1 != '0) begin
            w_stat_p1 = ECC_DED;
        end
    end

    for (genvar g = 0; g < DATA_W; g++) begin : g_extract
        localparam int POS = hamming_data_pos(g);
        assign w_data_p1[g] = w_corr_p1[POS];
    end

    // Check bits and the parity bit are not forwarded after correction.
    logic w_unused_corr;
    assign w_unused_corr = ^w_corr_p1;

    // ---- p2: corrected data and status, held while the consumer stalls ----
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_data_p2 <= '0;
            r_sec_p2  <= 1'b0;
            r_ded_p2  <= 1'b0;
        end else if (w_adv && r_vld_p1) begin
            r_data_p2 <= w_data_p1;
            r_sec_p2  <= (w_stat_p1 == ECC_SEC);
            r_ded_p2  <= (w_stat_p1 == ECC_DED);
        end
    end

    assign out_valid = r_vld_p2;
    assign out_data  = r_data_p2;
    assign out_sec   = r_sec_p2;
    assign out_ded   = r_ded_p2;

`ifdef HAMMING_ERR_CNT_EN
    logic             w_fire;
    logic [CNT_W-1:0] r_cnt_sec;
    logic [CNT_W-1:0] r_cnt_ded;

    assign w_fire = r_vld_p2 & out_ready;

    // Saturating error counters; a clear in the same cycle overrides an increment.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt_sec <= '0;
            r_cnt_ded <= '0;
        end else if (cnt_clr) begin
            r_cnt_sec <= '0;
            r_cnt_ded <= '0;
        end else begin
            if (w_fire && r_sec_p2 && !(&r_cnt_sec)) begin
                r_cnt_sec <= r_cnt_sec + CNT_W'(1);
            end
            if (w_fire && r_ded_p2 && !(&r_cnt_ded)) begin
                r_cnt_ded <= r_cnt_ded + CNT_W'(1);
            end
        end
    end

    assign cnt_sec = r_cnt_sec;
    assign cnt_ded = r_cnt_ded;
`else
    logic w_unused_clr;
    assign w_unused_clr = cnt_clr;
    assign cnt_sec      = '0;
    assign cnt_ded      = '0;
`endif

endmodule
